sigma_delta_adc: RTL and testbench
==================================

Name: sigma_delta_adc

Overview:
First-order delta-sigma ADC. It is the receive-side counterpart of the team's delta-sigma audio DAC and digitises analog input, for example tape or line-in. An external comparator (or LVDS pair) compares the analog input against an RC integrator. The integrator is driven by fb_out. The block registers the 1-bit comparator stream, closes the feedback loop and decimates the stream with a boxcar ones-counter. The result is an unsigned sample in excess-2^(DECB-1) format, the same format the DAC consumes.

Parameters:
DECB, 8, log2 of decimation window in ce ticks; also the width of the sample output
SETTLE, 2, number of complete windows discarded after reset before valid is first asserted (0..15)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low; clock clock
ce  in  1  oversampling tick; all loop and decimator state advances only on clocks with ce=1
cmp_in  in  1  asynchronous comparator result; 1 = analog input above integrator voltage
fb_out  out  1  feedback bit to external RC integrator (3k3/4n7 class); place the flop in the IOB
sample  out  DECB  decimated result, unsigned, mid-scale 2^(DECB-1)
valid  out  1  one-clock pulse when sample updates
overrange  out  1  set when the last window counted 2^DECB ones (sample is clamped)

Behaviour:
- Input synchroniser:
  - cmp_in passes through 2 flops clocked every clock, independent of ce, giving cmp_s.
  - Both flops reset to 0.
- Feedback:
  - On each ce clock: fb_out <= cmp_s.
  - No other logic may sit between the flop and the pin.
- Decimator state:
  - wcnt: DECB-bit tick counter.
  - acc: DECB+1-bit ones accumulator.
  - On each ce clock: wcnt <= wcnt+1 (wraps naturally).
- Window close: the ce clock with wcnt = 2^DECB-1.
  - total = acc + cmp_s, range 0..2^DECB.
  - acc <= 0.
  - If state=RUN:
    - sample <= min(total, 2^DECB-1).
    - overrange <= (total = 2^DECB).
    - valid <= 1 for exactly one clock.
  - If state=SETTLE: sample, overrange and valid are unchanged; valid stays 0.
- Other ce clocks: acc <= acc + cmp_s.
- Clocks with ce=0:
  - fb_out, wcnt, acc, state, sample and overrange all hold.
  - valid = 0.
- Latency:
  - sample and valid are registered on the window-close edge, so they are visible on the following clock.
  - Comparator-to-accumulator latency is 2 clocks (synchroniser) plus the sampling ce.
- State machine:
  - SETTLE:
    - scnt counts closed windows.
    - When scnt = SETTLE-1 at a window close, go to RUN; that closing window is still discarded.
  - RUN:
    - Terminal state; reset is the only exit.
  - If SETTLE = 0, reset enters RUN directly.
- Reset values:
  - fb_out=0, sample=0, valid=0, overrange=0.
  - acc=0, wcnt=0, scnt=0.
  - state = SETTLE, or RUN when SETTLE=0.
- Reset mid-window:
  - The partial window is discarded and sample is cleared.
  - The first valid comes after SETTLE+1 full windows counted from reset release.
- Simultaneous events:
  - Reset has priority over ce.
  - A window close with overrange updates sample to all-ones and sets overrange in the same edge.
  - overrange clears at the next RUN window close that has total < 2^DECB.
- Sample cadence is exactly 2^DECB ce ticks; valid pulses never merge, even when ce=1 continuously.

Test Plan:
1. DECB=4, SETTLE=1, ce=1 always, cmp_in=0 -> first valid on clock 33 after reset release (32 ce ticks + register), sample=0x0, overrange=0; fb_out stays 0.
2. DECB=4, SETTLE=1, cmp_in=1 held -> fb_out=1 from clock 3; first valid sample=0xF, overrange=1; valid period 16 clocks.
3. DECB=4, SETTLE=0, cmp_in toggling every clock -> every sample=0x8; valid exactly one clock wide every 16 clocks.
4. ce asserted every 3rd clock, cmp_in high for 3 of every 16 ce ticks -> sample=0x3; valid spacing 48 clocks; all state frozen on non-ce clocks.
5. Assert reset for one clock mid-window while cmp_in=1 -> next clock: sample=0, valid=0, overrange=0, fb_out=0; with SETTLE=2, next valid occurs only after 3 full windows.
6. Closed loop: bench models the RC integrator driven by fb_out with the comparator against an analog level of 0.25 FS, DECB=8 -> steady-state sample within 0x40 ±2, overrange=0.

Source files
------------

// File: rtl/sigma_delta_adc_if.sv
// Sample-side bundle of the delta-sigma ADC: oversampling tick and comparator in,
// feedback bit, decimated sample, valid strobe and overrange out.
interface sigma_delta_adc_if #(
    parameter int DECB = 8
);
    logic            ce;
    logic            cmp_in;
    logic            fb_out;
    logic [DECB-1:0] sample;
    logic            valid;
    logic            overrange;
    logic            state_dbg;

    // valid is a one-clock strobe with no ready: sample and overrange are stable
    // from the valid clock until the next valid clock, and the consumer must take
    // the word on that clock because there is no back-pressure.
    modport master (
        output ce, cmp_in,
        input  fb_out, sample, valid, overrange, state_dbg
    );

    modport slave (
        input  ce, cmp_in,
        output fb_out, sample, valid, overrange, state_dbg
    );
endinterface

// File: rtl/sigma_delta_adc.sv
// First-order delta-sigma ADC: synchronises the comparator, closes the loop through
// fb_out and decimates with a boxcar ones-counter into an excess-2^(DECB-1) sample.
module sigma_delta_adc #(
    parameter int DECB   = 8,
    parameter int SETTLE = 2
) (
    input  logic             clock,
    input  logic             reset,
    sigma_delta_adc_if.slave bus
);
    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    localparam state_t            ST_INIT   = (SETTLE == 0) ? ST_RUN : ST_SETTLE;
    localparam logic [3:0]        SCNT_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
    localparam logic [DECB-1:0]   WCNT_LAST = '1;

    logic            r_sync1;
    logic            r_sync2;
    logic            r_fb;
    logic [DECB-1:0] r_wcnt;
    logic [DECB:0]   r_acc;
    logic [3:0]      r_scnt;
    logic [DECB-1:0] r_sample;
    logic            r_valid;
    logic            r_ovr;
    state_t          r_state;
    state_t          w_state_next;
    logic [3:0]      w_scnt_next;
    logic            w_close;
    logic [DECB:0]   w_total;

    assign w_close = bus.ce && (r_wcnt == WCNT_LAST);
    assign w_total = r_acc + {{DECB{1'b0}}, r_sync2};

    // Two-flop synchroniser runs every clock so the ce rate never adds metastability risk.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.cmp_in;
            r_sync2 <= r_sync1;
        end
    end

    // Feedback flop drives the pin directly so it can be packed into the output cell.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_fb <= 1'b0;
        end else if (bus.ce) begin
            r_fb <= r_sync2;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_INIT;
            r_scnt  <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_scnt  <= w_scnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_scnt_next  = r_scnt;
        case (r_state)
            ST_SETTLE: begin
                if (w_close) begin
                    if (r_scnt == SCNT_LAST) begin
                        w_state_next = ST_RUN;
                    end else begin
                        w_scnt_next = r_scnt + 4'd1;
                    end
                end
            end
            ST_RUN: begin
                w_state_next = ST_RUN;
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    // total can only reach 2^DECB with every tick a one, so its top bit is the clamp flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wcnt   <= '0;
            r_acc    <= '0;
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (bus.ce) begin
                r_wcnt <= r_wcnt + 1'b1;
                if (w_close) begin
                    r_acc <= '0;
                    if (r_state == ST_RUN) begin
                        r_sample <= w_total[DECB] ? '1 : w_total[DECB-1:0];
                        r_ovr    <= w_total[DECB];
                        r_valid  <= 1'b1;
                    end
                end else begin
                    r_acc <= w_total;
                end
            end
        end
    end

    assign bus.fb_out    = r_fb;
    assign bus.sample    = r_sample;
    assign bus.valid     = r_valid;
    assign bus.overrange = r_ovr;
    assign bus.state_dbg = r_state;
endmodule

// File: tb/tb_sigma_delta_adc.sv
// Bench for sigma_delta_adc: four instances with different DECB/SETTLE, a vector
// table for steady patterns, hand-written reset and closed-loop sequences.
module tb_sigma_delta_adc;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic ce = 1'b0;
    logic cmp = 1'b0;
    logic cmp_model = 1'b0;

    always #5 clock = ~clock;

    sigma_delta_adc_if #(.DECB(4)) if_a ();
    sigma_delta_adc_if #(.DECB(4)) if_b ();
    sigma_delta_adc_if #(.DECB(4)) if_c ();
    sigma_delta_adc_if #(.DECB(8)) if_d ();

    assign if_a.ce = ce;
    assign if_a.cmp_in = cmp;
    assign if_b.ce = ce;
    assign if_b.cmp_in = cmp;
    assign if_c.ce = ce;
    assign if_c.cmp_in = cmp;
    assign if_d.ce = ce;
    assign if_d.cmp_in = cmp_model;

    sigma_delta_adc #(.DECB(4), .SETTLE(1)) u_a (.clock(clock), .reset(reset), .bus(if_a));
    sigma_delta_adc #(.DECB(4), .SETTLE(0)) u_b (.clock(clock), .reset(reset), .bus(if_b));
    sigma_delta_adc #(.DECB(4), .SETTLE(2)) u_c (.clock(clock), .reset(reset), .bus(if_c));
    sigma_delta_adc #(.DECB(8), .SETTLE(2)) u_d (.clock(clock), .reset(reset), .bus(if_d));

    int sel = 0;
    logic       w_valid, w_ovr, w_fb, w_state;
    logic [7:0] w_sample;

    always_comb begin
        w_valid = if_a.valid;  w_ovr = if_a.overrange;  w_fb = if_a.fb_out;
        w_state = if_a.state_dbg;  w_sample = {4'd0, if_a.sample};
        case (sel)
            1: begin
                w_valid = if_b.valid;  w_ovr = if_b.overrange;  w_fb = if_b.fb_out;
                w_state = if_b.state_dbg;  w_sample = {4'd0, if_b.sample};
            end
            2: begin
                w_valid = if_c.valid;  w_ovr = if_c.overrange;  w_fb = if_c.fb_out;
                w_state = if_c.state_dbg;  w_sample = {4'd0, if_c.sample};
            end
            3: begin
                w_valid = if_d.valid;  w_ovr = if_d.overrange;  w_fb = if_d.fb_out;
                w_state = if_d.state_dbg;  w_sample = if_d.sample;
            end
            default: ;
        endcase
    end

    // ecnt = number of clock edges since reset release (0 while in reset)
    int ecnt = 0;
    always @(posedge clock) begin
        if (!reset) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    typedef struct {
        int         sel;
        int         ce_per;
        int         kind;      // 0: cmp low, 1: cmp high, 2: toggle each clock, 3: 3-of-16 ticks
        int         n_win;
        int         n_skip;
        logic [7:0] exp_sample;
        logic       exp_ovr;
        logic       exp_state;
        int         first;
        int         period;
    } vec_t;

    vec_t       vecs[4];
    logic [8:0] exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         mon_en = 0;
    int         mon_skip = 0;
    int         exp_first = 0;
    int         exp_period = 0;

    task automatic check(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic monitor();
        int         last_v;
        int         nval;
        logic [8:0] e;
        last_v = -1;
        nval = 0;
        forever begin
            @(negedge clock);
            if (ecnt == 0) begin
                last_v = -1;
                nval = 0;
            end else if (mon_en != 0 && w_valid) begin
                if (last_v < 0) check("first_valid_edge", ecnt, exp_first);
                else            check("valid_period", ecnt - last_v, exp_period);
                last_v = ecnt;
                nval++;
                if (nval > mon_skip) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("sample", int'(w_sample), int'(e[7:0]));
                        check("overrange", int'(w_ovr), int'(e[8]));
                    end
                end
            end
        end
    endtask

    task automatic drive(input vec_t v, input int c);
        ce = (((c + 1) % v.ce_per) == 0);
        case (v.kind)
            0: cmp = 1'b0;
            1: cmp = 1'b1;
            2: cmp = ((c % 2) == 1);
            default: cmp = (((c / 3) % 16) < 3);
        endcase
    endtask

    task automatic check_reset_state(input logic exp_state);
        check("rst_sample", int'(w_sample), 0);
        check("rst_valid", int'(w_valid), 0);
        check("rst_ovr", int'(w_ovr), 0);
        check("rst_fb", int'(w_fb), 0);
        check("rst_state", int'(w_state), int'(exp_state));
    endtask

    task automatic run_vec(input vec_t v);
        int   n;
        logic prev_fb;
        sel = v.sel;
        mon_en = 0;
        reset = 1'b0;
        ce = 1'b0;
        cmp = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_state(v.exp_state);
        for (int i = 0; i < v.n_win; i++) exp_q.push_back({v.exp_ovr, v.exp_sample});
        mon_skip = v.n_skip;
        exp_first = v.first;
        exp_period = v.period;
        mon_en = 1;
        reset = 1'b1;
        drive(v, 0);
        prev_fb = 1'b0;
        n = v.first + (v.n_win + v.n_skip - 1) * v.period + 2;
        for (int c = 1; c <= n; c++) begin
            @(posedge clock);
            #1;
            if (!ce) begin
                check("fb_hold", int'(w_fb), int'(prev_fb));
                check("valid_idle", int'(w_valid), 0);
            end
            if (v.kind == 0) check("fb_low", int'(w_fb), 0);
            if (v.kind == 1) check("fb_high", int'(w_fb), (c >= 3) ? 1 : 0);
            prev_fb = w_fb;
            drive(v, c);
        end
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        mon_en = 0;
    endtask

    initial begin
        int   nv;
        int   s;
        real  vint;
        real  alpha;

        fork
            monitor();
        join_none

        // {sel, ce_per, kind, n_win, n_skip, sample, ovr, reset state, first edge, period}
        // The toggle case skips its first window: the two synchroniser reset zeros
        // leave only 7 ones in it.
        vecs[0] = '{0, 1, 0, 3, 0, 8'h00, 1'b0, 1'b0, 32, 16};
        vecs[1] = '{0, 1, 1, 3, 0, 8'h0F, 1'b1, 1'b0, 32, 16};
        vecs[2] = '{1, 1, 2, 4, 1, 8'h08, 1'b0, 1'b1, 16, 16};
        vecs[3] = '{1, 3, 3, 3, 0, 8'h03, 1'b0, 1'b1, 48, 48};
        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Reset pulse mid-window with SETTLE=2 and cmp held high
        sel = 2;
        mon_en = 0;
        reset = 1'b0;
        ce = 1'b1;
        cmp = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_reset_state(1'b0);
        exp_first = 48;
        exp_period = 16;
        mon_skip = 0;
        exp_q.push_back({1'b1, 8'h0F});
        mon_en = 1;
        reset = 1'b1;
        repeat (56) @(posedge clock);
        #1;
        check("pre_reset_sample", int'(w_sample), 15);
        check("pre_reset_ovr", int'(w_ovr), 1);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_reset_state(1'b0);
        exp_q.push_back({1'b1, 8'h0F});
        reset = 1'b1;
        repeat (50) @(posedge clock);
        #1;
        check("reset_queue_drained", exp_q.size(), 0);
        exp_q.delete();
        mon_en = 0;

        // Closed loop with an RC integrator model and a 0.25 FS analog level, ce every 4th clock
        sel = 3;
        alpha = 1.0 / 2048.0;
        vint = 0.0;
        reset = 1'b0;
        ce = 1'b0;
        cmp_model = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_reset_state(1'b0);
        reset = 1'b1;
        nv = 0;
        for (int c = 1; c <= 12000 && nv < 6; c++) begin
            @(posedge clock);
            #1;
            vint = vint + alpha * ((w_fb ? 1.0 : 0.0) - vint);
            cmp_model = (vint < 0.25);
            ce = (((c + 1) % 4) == 0);
            if (w_valid) begin
                nv++;
                if (nv >= 2) begin
                    s = int'(w_sample);
                    total++;
                    if (s < 62 || s > 66) begin
                        bad++;
                        $display("FAIL loop_sample: got %0d expected 64 +/- 2", s);
                    end
                    check("loop_ovr", int'(w_ovr), 0);
                end
            end
        end
        check("loop_valid_count", nv, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
